// File: rtl/arp_recv.sv
// ARP frame receiver: strips preamble/SFD from a GMII-style byte stream, filters
// ARP frames addressed to this node, captures the address fields and checks the FCS.
module arp_recv #(
  parameter bit CHECK_TPA = 1'b1,
  parameter int MAX_LEN   = 1522,
  parameter int MIN_LEN   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_dv,
  input  logic        i_rx_er,
  input  logic [47:0] i_my_mac,
  input  logic [31:0] i_my_ip,
  output logic        o_valid,
  output logic        o_err,
  output logic        o_busy,
  output logic [15:0] o_operation,
  output logic [47:0] o_src_mac,
  output logic [47:0] o_sha,
  output logic [31:0] o_spa,
  output logic [47:0] o_tha,
  output logic [31:0] o_tpa,
  output logic [2:0]  o_dbg_state
);

  // Handshake: o_valid / o_err are single-cycle strobes with no backpressure; the
  // result fields change only together with o_valid and hold until the next one.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    FRAME    = 3'd2,
    CHECK    = 3'd3,
    DROP     = 3'd4
  } state_e;

  localparam logic [10:0] MAX_CNT     = 11'(MAX_LEN);
  localparam logic [10:0] MIN_CNT     = 11'(MIN_LEN);
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [47:0] BCAST_MAC   = 48'hFFFF_FFFF_FFFF;

  state_e      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [47:0] acc_q, acc_d;

  // Shadow capture registers, filled while the frame streams in.
  logic [47:0] src_mac_s_q, src_mac_s_d;
  logic [15:0] oper_s_q, oper_s_d;
  logic [47:0] sha_s_q, sha_s_d;
  logic [31:0] spa_s_q, spa_s_d;
  logic [47:0] tha_s_q, tha_s_d;
  logic [31:0] tpa_s_q, tpa_s_d;

  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [15:0] operation_q, operation_d;
  logic [47:0] src_mac_q, src_mac_d;
  logic [47:0] sha_q, sha_d;
  logic [31:0] spa_q, spa_d;
  logic [47:0] tha_q, tha_d;
  logic [31:0] tpa_q, tpa_d;

  logic [47:0] word;
  logic [31:0] crc_next;
  logic        filter_fail;
  logic        frame_good;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  // The field ending on the current byte, MSB byte first.
  assign word       = {acc_q[39:0], i_rx_data};
  assign crc_next   = crc_byte(crc_q, i_rx_data);
  assign frame_good = (cnt_q >= MIN_CNT) && (crc_q == CRC_RESIDUE);

  always_comb begin
    filter_fail = 1'b0;
    if (cnt_q == 11'd5) begin
      filter_fail = (word != BCAST_MAC) && (word != i_my_mac);
    end else if (cnt_q == 11'd13) begin
      filter_fail = (word[15:0] != 16'h0806);
    end else if (cnt_q == 11'd15) begin
      filter_fail = (word[15:0] != 16'h0001);
    end else if (cnt_q == 11'd17) begin
      filter_fail = (word[15:0] != 16'h0800);
    end else if (cnt_q == 11'd18) begin
      filter_fail = (word[7:0] != 8'h06);
    end else if (cnt_q == 11'd19) begin
      filter_fail = (word[7:0] != 8'h04);
    end else if (cnt_q == 11'd21) begin
      filter_fail = (word[15:0] != 16'd1) && (word[15:0] != 16'd2);
    end else if (cnt_q == 11'd41) begin
      filter_fail = CHECK_TPA && (word[31:0] != i_my_ip);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    acc_d       = acc_q;
    src_mac_s_d = src_mac_s_q;
    oper_s_d    = oper_s_q;
    sha_s_d     = sha_s_q;
    spa_s_d     = spa_s_q;
    tha_s_d     = tha_s_q;
    tpa_s_d     = tpa_s_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    operation_d = operation_q;
    src_mac_d   = src_mac_q;
    sha_d       = sha_q;
    spa_d       = spa_q;
    tha_d       = tha_q;
    tpa_d       = tpa_q;

    case (state_q)
      IDLE: begin
        if (i_rx_dv) begin
          state_d = (i_rx_data == 8'h55) ? PREAMBLE : DROP;
        end
      end

      PREAMBLE: begin
        if (!i_rx_dv) begin
          state_d = IDLE;
        end else if (i_rx_data == 8'hD5) begin
          state_d = FRAME;
          cnt_d   = 11'd0;
          crc_d   = CRC_INIT;
        end else if (i_rx_data != 8'h55) begin
          state_d = DROP;
        end
      end

      FRAME: begin
        // Pulses are registered on the exit edge so they appear in the CHECK cycle.
        if (!i_rx_dv) begin
          state_d = CHECK;
          if (frame_good) begin
            valid_d     = 1'b1;
            operation_d = oper_s_q;
            src_mac_d   = src_mac_s_q;
            sha_d       = sha_s_q;
            spa_d       = spa_s_q;
            tha_d       = tha_s_q;
            tpa_d       = tpa_s_q;
          end else begin
            err_d = 1'b1;
          end
        end else if (i_rx_er || (cnt_q >= MAX_CNT)) begin
          err_d   = 1'b1;
          state_d = DROP;
        end else begin
          crc_d = crc_next;
          cnt_d = cnt_q + 11'd1;
          acc_d = word;
          case (cnt_q)
            11'd11:  src_mac_s_d = word;
            11'd21:  oper_s_d    = word[15:0];
            11'd27:  sha_s_d     = word;
            11'd31:  spa_s_d     = word[31:0];
            11'd37:  tha_s_d     = word;
            11'd41:  tpa_s_d     = word[31:0];
            default: ;
          endcase
          if (filter_fail) begin
            state_d = DROP;
          end
        end
      end

      CHECK: begin
        state_d = IDLE;
      end

      DROP: begin
        if (!i_rx_dv) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      crc_q       <= CRC_INIT;
      acc_q       <= '0;
      src_mac_s_q <= '0;
      oper_s_q    <= '0;
      sha_s_q     <= '0;
      spa_s_q     <= '0;
      tha_s_q     <= '0;
      tpa_s_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      operation_q <= '0;
      src_mac_q   <= '0;
      sha_q       <= '0;
      spa_q       <= '0;
      tha_q       <= '0;
      tpa_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      acc_q       <= acc_d;
      src_mac_s_q <= src_mac_s_d;
      oper_s_q    <= oper_s_d;
      sha_s_q     <= sha_s_d;
      spa_s_q     <= spa_s_d;
      tha_s_q     <= tha_s_d;
      tpa_s_q     <= tpa_s_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      operation_q <= operation_d;
      src_mac_q   <= src_mac_d;
      sha_q       <= sha_d;
      spa_q       <= spa_d;
      tha_q       <= tha_d;
      tpa_q       <= tpa_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_err       = err_q;
  assign o_busy      = (state_q != IDLE);
  assign o_operation = operation_q;
  assign o_src_mac   = src_mac_q;
  assign o_sha       = sha_q;
  assign o_spa       = spa_q;
  assign o_tha       = tha_q;
  assign o_tpa       = tpa_q;
  assign o_dbg_state = state_q;

endmodule

// File: doc/arp_recv.md
Name: arp_recv

Overview:
- Byte-wide Ethernet receiver that parses incoming ARP frames from the PHY receive interface (8-bit data plus data-valid, GMII-style, one byte per clk).
- Strips preamble/SFD, filters on destination MAC, EtherType and ARP header fields, captures sender/target addresses and verifies the FCS.
- Presents a one-cycle result strobe to the ARP responder logic; it is the receive-side counterpart of the ARP frame transmitter.

Parameters:
- CHECK_TPA, 1, when 1 frames whose TPA differs from i_my_ip are dropped; when 0 any TPA is accepted.
- MAX_LEN, 1522, maximum bytes after SFD including FCS; longer frames are aborted as errors.
- MIN_LEN, 64, minimum bytes after SFD including FCS; shorter frames are flagged as errors.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- i_rx_data  input  8  received byte, valid when i_rx_dv=1
- i_rx_dv  input  1  receive data valid, high for the whole frame including preamble
- i_rx_er  input  1  PHY receive error
- i_my_mac  input  48  local MAC address
- i_my_ip  input  32  local IPv4 address
- o_valid  output  1  one-cycle pulse: good ARP frame received, outputs below updated
- o_err  output  1  one-cycle pulse: frame passed the filter but failed FCS, length or rx_er checks
- o_busy  output  1  high while state != IDLE
- o_operation  output  16  ARP OPER field (1 = request, 2 = reply)
- o_src_mac  output  48  Ethernet source MAC
- o_sha / o_spa / o_tha / o_tpa  output  48/32/48/32  ARP address fields

Behaviour:
- Reset values: all outputs 0; state IDLE; CRC register 0xFFFFFFFF.
- States: IDLE, PREAMBLE, FRAME, CHECK, DROP.
- IDLE:
  - i_rx_dv=1 and byte 0x55 -> PREAMBLE.
  - i_rx_dv=1 with any other byte -> DROP.
- PREAMBLE:
  - 0x55 stays in PREAMBLE.
  - 0xD5 -> FRAME; byte counter cleared to 0 and CRC register loaded with 0xFFFFFFFF.
  - Any other byte, or i_rx_dv=0 -> DROP / IDLE respectively.
- FRAME:
  - Each byte with i_rx_dv=1 updates the CRC and increments the 11-bit byte counter.
  - Fields are captured by counter value, MSB byte first:
    - 0-5 dst MAC
    - 6-11 src MAC
    - 12-13 EtherType
    - 14-21 ARP header
    - 22-27 SHA
    - 28-31 SPA
    - 32-37 THA
    - 38-41 TPA
    - remainder is pad + FCS, ignored except by the CRC.
- Filter, evaluated on the last byte of each field. Any mismatch -> DROP with no pulse:
  - dst MAC must be FF:FF:FF:FF:FF:FF or i_my_mac.
  - EtherType must be 0x0806.
  - HTYPE 0x0001, PTYPE 0x0800, HLEN 0x06, PLEN 0x04.
  - OPER must be 1 or 2.
  - TPA must equal i_my_ip when CHECK_TPA=1.
- Errors inside FRAME:
  - i_rx_er=1 -> o_err pulse next cycle, then DROP.
  - Counter reaching MAX_LEN with i_rx_dv still 1 -> o_err pulse next cycle, then DROP.
- End of frame: i_rx_dv=0 in FRAME -> CHECK. The CHECK cycle decides:
  - good = counter >= MIN_LEN and CRC register == 0xDEBB20E3.
  - good: copy shadow capture registers to outputs and pulse o_valid.
  - otherwise pulse o_err; outputs unchanged.
  - In both cases -> IDLE.
  - Latency: o_valid/o_err are high exactly one cycle after the first cycle with i_rx_dv=0.
- CRC: reflected CRC-32 (poly 0xEDB88320), LSB-first, init 0xFFFFFFFF, no final inversion. It covers dst MAC through FCS inclusive, one byte per clk.
- Output registers change only on o_valid and hold otherwise; a dropped or errored frame never corrupts them.
- DROP: wait for i_rx_dv=0, then IDLE. Back-to-back frames need at least one idle cycle; IDLE accepts a new frame on the cycle after CHECK or DROP exit.
- o_valid and o_err are mutually exclusive.
- Reset asserted mid-frame: immediate return to IDLE with all outputs 0. Frame bytes arriving after reset release are treated as a new frame start and fail preamble detection unless they are 0x55.

Test Plan:
- Broadcast ARP request, src 00:11:22:33:44:55, SPA 192.168.1.10, TPA 192.168.1.100 = i_my_ip, 7x55+D5, 18 pad bytes, correct FCS -> one o_valid:
  - o_operation=1, o_sha=001122334455, o_spa=C0A8010A, o_tpa=C0A80164
  - o_err=0
- Same frame with one FCS bit flipped -> o_err pulse one cycle after rx_dv falls; o_valid=0; outputs keep previous values.
- Unicast to 02:00:00:00:00:01 = i_my_mac, OPER=2, then a frame with TPA 192.168.1.99 (CHECK_TPA=1) -> the first gives o_valid with o_operation=2; the second produces no pulse.
- EtherType 0x0800 frame, then i_rx_er asserted at byte 20 of an otherwise good ARP frame -> the first produces no pulse; the second gives o_err, o_busy high until rx_dv falls.
- Good frame truncated to 50 bytes after SFD with valid FCS over those bytes -> o_err.
- Two good frames separated by one idle cycle -> two o_valid pulses.
- rst_n pulsed low at byte 30 -> o_busy=0 and outputs 0 immediately; the next good frame is received correctly.
